// File: rtl/irq_ctrl_if.sv
// Port-mapped register bus plus the interrupt request/acknowledge pair between
// the PicoBlaze (master) and the interrupt controller (slave).
interface irq_ctrl_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ren;
  logic       wen;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output address, data_in, ren, wen, interrupt_ack,
    input  data_out, interrupt
  );

  modport slave (
    input  address, data_in, ren, wen, interrupt_ack,
    output data_out, interrupt
  );
endinterface

// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller: pending/mask/edge registers, fixed priority
// (bit 0 highest) and an IDLE/ASSERT/SERVICE handshake to the PicoBlaze interrupt pin.
module irq_ctrl #(
  parameter logic [7:0] ADDR_BASE = 8'h10
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] irq_src,
  irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q;
  logic       irq_q;
  logic [7:0] vec_q;

  logic [7:0] src_q, src_qq;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] edge_q, edge_d;

  logic [7:0] offset;
  logic       hit;
  logic       wr_pend, wr_mask, wr_edge, wr_eoi;
  logic [7:0] set_bits, clr_bits;
  logic [7:0] act;
  logic [7:0] live_vec;
  logic [7:0] rd_data;

  // Address decode; offsets outside 0..3 (including wrap below the base) miss.
  assign offset  = bus.address - ADDR_BASE;
  assign hit     = (offset[7:2] == 6'd0);
  assign wr_pend = bus.wen & hit & (offset[1:0] == 2'd0);
  assign wr_mask = bus.wen & hit & (offset[1:0] == 2'd1);
  assign wr_edge = bus.wen & hit & (offset[1:0] == 2'd2);
  assign wr_eoi  = bus.wen & hit & (offset[1:0] == 2'd3);

  // Edge sources set on a 0->1 of the synchronised input, level sources while high.
  assign set_bits = src_q & (~edge_q | ~src_qq);
  assign clr_bits = wr_pend ? bus.data_in : 8'h00;

  // Set is OR'd in after the clear so a new request wins over a same-cycle W1C.
  assign pend_d = (pend_q & ~clr_bits) | set_bits;
  assign mask_d = wr_mask ? bus.data_in : mask_q;
  assign edge_d = wr_edge ? bus.data_in : edge_q;

  assign act = pend_q & mask_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    live_vec = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) live_vec = {1'b1, 4'b0000, 3'(i)};
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      src_q  <= 8'h00;
      src_qq <= 8'h00;
      pend_q <= 8'h00;
      mask_q <= 8'h00;
      edge_q <= 8'h00;
    end else begin
      src_q  <= irq_src;
      src_qq <= src_q;
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      vec_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (|act) begin
            state_q <= ASSERT;
            irq_q   <= 1'b1;
          end
        end
        ASSERT: begin
          if (bus.interrupt_ack) begin
            vec_q   <= live_vec;
            state_q <= SERVICE;
            irq_q   <= 1'b0;
          end else if (act == 8'h00) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_eoi) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (bus.ren && hit) begin
      case (offset[1:0])
        2'd0:    rd_data = pend_q;
        2'd1:    rd_data = mask_q;
        2'd2:    rd_data = edge_q;
        default: rd_data = (state_q == SERVICE) ? vec_q : live_vec;
      endcase
    end
  end

  assign bus.data_out  = rd_data;
  assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register-access vector table, then hand-written
// sequences for latency, priority/freeze, masking, set/clear collision and reset.
module tb_irq_ctrl;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk_in;
  logic       rst;
  logic [7:0] irq_src;

  irq_ctrl_if bus ();

  irq_ctrl #(.ADDR_BASE(BASE)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .irq_src (irq_src),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic       wen;
    logic       ren;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    bus.address = addr;
    bus.data_in = data;
    bus.wen     = 1'b1;
    tick();
    bus.wen     = 1'b0;
  endtask

  // Expected value is queued with the stimulus and popped when the read data is sampled.
  task automatic read_check(input logic [7:0] addr, input logic r, input logic [7:0] exp,
                            input string name);
    exp_t e;
    logic [7:0] got;
    sb_q.push_back('{exp: exp, name: name});
    bus.address = addr;
    bus.ren     = r;
    #1;
    got = bus.data_out;
    bus.ren = 1'b0;
    e = sb_q.pop_front();
    check(e.name, got, e.exp);
  endtask

  task automatic pulse_ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic wait_irq(input logic exp, input int max_cycles, input string name);
    int n = 0;
    while (bus.interrupt !== exp && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, {7'b0, bus.interrupt}, {7'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, BASE + 8'd1, 8'h01, 8'h00, "wr_mask"};
    vecs[1]  = '{1'b1, 1'b0, BASE + 8'd2, 8'h01, 8'h00, "wr_edge"};
    vecs[2]  = '{1'b0, 1'b1, BASE + 8'd1, 8'h00, 8'h01, "rd_mask"};
    vecs[3]  = '{1'b0, 1'b1, BASE + 8'd2, 8'h00, 8'h01, "rd_edge"};
    vecs[4]  = '{1'b0, 1'b1, BASE + 8'd0, 8'h00, 8'h00, "rd_pend"};
    vecs[5]  = '{1'b0, 1'b1, BASE + 8'd3, 8'h00, 8'h00, "rd_vector"};
    vecs[6]  = '{1'b1, 1'b0, BASE + 8'd4, 8'hFF, 8'h00, "wr_out_of_range"};
    vecs[7]  = '{1'b0, 1'b1, BASE + 8'd4, 8'h00, 8'h00, "rd_above_range"};
    vecs[8]  = '{1'b0, 1'b1, BASE - 8'd1, 8'h00, 8'h00, "rd_below_range"};
    vecs[9]  = '{1'b0, 1'b0, BASE + 8'd1, 8'h00, 8'h00, "rd_no_strobe"};
    vecs[10] = '{1'b0, 1'b1, BASE + 8'd1, 8'h00, 8'h01, "rd_mask_intact"};

    rst               = 1'b1;
    irq_src           = 8'h00;
    bus.address       = 8'h00;
    bus.data_in       = 8'h00;
    bus.ren           = 1'b0;
    bus.wen           = 1'b0;
    bus.interrupt_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_interrupt", {7'b0, bus.interrupt}, 8'h00);
    check("reset_data_out", bus.data_out, 8'h00);
    for (int a = 0; a < 4; a++) read_check(BASE + 8'(a), 1'b1, 8'h00, "reset_reg");

    // 1. Register access table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wen) bus_write(vecs[i].addr, vecs[i].data);
      else read_check(vecs[i].addr, vecs[i].ren, vecs[i].exp, vecs[i].name);
    end
    check("t1_interrupt", {7'b0, bus.interrupt}, 8'h00);

    // 2. Single edge source, exact latency
    irq_src = 8'h01;
    tick();
    check("t2_lat_edge1", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("t2_lat_edge2", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE, 1'b1, 8'h01, "t2_pend_set");
    tick();
    check("t2_lat_edge3", {7'b0, bus.interrupt}, 8'h01);
    irq_src = 8'h00;
    pulse_ack();
    check("t2_ack_drops_irq", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE + 8'd3, 1'b1, 8'h80, "t2_vector");
    bus_write(BASE, 8'h01);
    bus_write(BASE + 8'd3, 8'h00);
    tick();
    tick();
    check("t2_after_eoi", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE, 1'b1, 8'h00, "t2_pend_cleared");

    // 3. Priority and freeze
    bus_write(BASE + 8'd1, 8'hFF);
    bus_write(BASE + 8'd2, 8'h00);
    irq_src = 8'h24;
    wait_irq(1'b1, 6, "t3_irq_rise");
    read_check(BASE + 8'd3, 1'b1, 8'h82, "t3_live_vector");
    pulse_ack();
    check("t3_ack_drops_irq", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE + 8'd3, 1'b1, 8'h82, "t3_frozen");
    irq_src = 8'h25;
    tick();
    tick();
    tick();
    read_check(BASE, 1'b1, 8'h25, "t3_pend");
    read_check(BASE + 8'd3, 1'b1, 8'h82, "t3_still_frozen");
    check("t3_service_no_irq", {7'b0, bus.interrupt}, 8'h00);
    bus_write(BASE + 8'd3, 8'h00);
    check("t3_eoi_edge", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("t3_eoi_reassert", {7'b0, bus.interrupt}, 8'h01);
    read_check(BASE + 8'd3, 1'b1, 8'h80, "t3_live_after_eoi");
    irq_src = 8'h00;
    tick();
    tick();
    bus_write(BASE, 8'hFF);
    tick();
    check("t3_cleared_idle", {7'b0, bus.interrupt}, 8'h00);

    // 4. Masking
    bus_write(BASE + 8'd1, 8'h00);
    irq_src = 8'h08;
    tick();
    tick();
    tick();
    read_check(BASE, 1'b1, 8'h08, "t4_pend_masked");
    check("t4_masked_no_irq", {7'b0, bus.interrupt}, 8'h00);
    bus_write(BASE + 8'd1, 8'h08);
    check("t4_unmask_edge1", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("t4_unmask_edge2", {7'b0, bus.interrupt}, 8'h01);
    bus_write(BASE + 8'd1, 8'h00);
    check("t4_mask_edge1", {7'b0, bus.interrupt}, 8'h01);
    tick();
    check("t4_mask_drop", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE + 8'd3, 1'b1, 8'h00, "t4_live_idle");
    pulse_ack();
    bus_write(BASE + 8'd1, 8'h08);
    tick();
    check("t4_idle_reassert", {7'b0, bus.interrupt}, 8'h01);
    bus_write(BASE + 8'd1, 8'h00);
    tick();

    // 5. Set vs clear collision
    bus_write(BASE, 8'h08);
    read_check(BASE, 1'b1, 8'h08, "t5_level_collision");
    bus_write(BASE + 8'd2, 8'h10);
    irq_src = 8'h18;
    tick();
    bus_write(BASE, 8'h10);
    read_check(BASE, 1'b1, 8'h18, "t5_edge_collision");
    bus_write(BASE, 8'h10);
    read_check(BASE, 1'b1, 8'h08, "t5_edge_no_repend");
    irq_src = 8'h00;
    tick();
    tick();
    bus_write(BASE, 8'hFF);
    read_check(BASE, 1'b1, 8'h00, "t5_all_clear");

    // 6. Reset mid-service
    bus_write(BASE + 8'd1, 8'hFF);
    bus_write(BASE + 8'd2, 8'h00);
    irq_src = 8'hFF;
    wait_irq(1'b1, 6, "t6_irq_rise");
    pulse_ack();
    check("t6_in_service", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE, 1'b1, 8'hFF, "t6_pend_full");
    read_check(BASE + 8'd3, 1'b1, 8'h80, "t6_vector");
    irq_src = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_interrupt", {7'b0, bus.interrupt}, 8'h00);
    for (int a = 0; a < 4; a++) read_check(BASE + 8'(a), 1'b1, 8'h00, "t6_rst_reg");
    pulse_ack();
    tick();
    tick();
    check("t6_ack_ignored", {7'b0, bus.interrupt}, 8'h00);
    read_check(BASE + 8'd3, 1'b1, 8'h00, "t6_vector_after_ack");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Eight-input interrupt controller that sits directly downstream of the timer peripheral(s) and other BAMSE peripherals. It collects their interrupt outputs, latches them as pending, and applies a mask and a fixed priority. It drives the single PicoBlaze `interrupt` input with an ack/end-of-interrupt handshake, so software can identify the source through the same 8-bit port-mapped register bus the peripherals use.

## Interface
- `ADDR_BASE`, default `8'h10`: base port address. Registers occupy `ADDR_BASE+0` to `ADDR_BASE+3`.
- `clk_in`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high; clock `clk_in`.
- `irq_src`, in, 8: asynchronous interrupt requests. Bit 0 is the highest priority. Timer `tmr_interrupt` is wired to bit 0.
- `interrupt`, out, 1: interrupt request to the CPU.
- `interrupt_ack`, in, 1: one-cycle acknowledge from the CPU.
- `address`, in, 8: port address.
- `data_in`, in, 8: write data.
- `data_out`, out, 8: read data.
- `ren`, in, 1: read strobe.
- `wen`, in, 1: write strobe.

## Operation
- **Registers:**
  - +0 `PEND`: read. Writing 1 to a bit clears that bit (W1C).
  - +1 `MASK`: read/write. 1 enables the source.
  - +2 `EDGE`: read/write. 1 = rising-edge source, 0 = level source.
  - +3 `VECTOR`: read. Bit 7 = valid, bits 6:3 = 0, bits 2:0 = source index. Any write to +3 is EOI.
- **Input path:**
  - `src_q` is `irq_src` registered once.
  - `src_qq` is `src_q` delayed one cycle.
- **Pending set condition:**
  - Edge-mode bit i: `src_q[i] & ~src_qq[i]`.
  - Level-mode bit i: `src_q[i]`.
- **Pending update:** `PEND <= (PEND & ~clear) | set`. A set wins over a W1C clear of the same bit in the same cycle. A level source therefore stays pending while it is held high.
- **Active vector:** `act = PEND & MASK`. The live vector is the lowest set index in `act`. Valid = `|act`.
- **State machine (`IDLE`, `ASSERT`, `SERVICE`):**
  - `IDLE`: if `|act`, go to `ASSERT`. `interrupt_ack` is ignored in this state.
  - `ASSERT`: `interrupt` = 1.
    - If `interrupt_ack`: freeze the current live vector into `VECTOR`, then go to `SERVICE`.
    - Else if `act == 0` (cleared or masked before ack): return to `IDLE`.
  - `SERVICE`: `interrupt` = 0. `VECTOR` holds the frozen value. A write to +3 (EOI) goes to `IDLE`. The pending bit is not cleared by ack or EOI; software W1Cs `PEND` itself.
- **`VECTOR` read value:** in `IDLE` and `ASSERT`, reads return the live vector; in `SERVICE`, the frozen one.
- **`data_out`:** combinational. It is the addressed register when `ren` = 1 and `address` is in `ADDR_BASE..+3`, otherwise 0. Reads have no side effects.
- **Writes:** take effect on the edge where `wen` = 1 and `address` matches. Writes to `PEND` and `MASK` are allowed in any state.
- **Mid-operation reset:** `rst` in any state returns the block to `IDLE` on the next edge and clears all registers.

## Timing
- **Reset values:**
  - `interrupt` = 0, `data_out` = 0.
  - `PEND`, `MASK`, `EDGE`, `src_q`, `src_qq` = 0.
  - `VECTOR` frozen value = 0, state = `IDLE`.
- **Latency:** if `irq_src[i]` rises before edge k and the bit is unmasked in `IDLE`:
  - `src_q` = 1 after edge k.
  - `PEND[i]` = 1 after edge k+1.
  - `interrupt` = 1 after edge k+2.
- **Ack:** `interrupt_ack` sampled high at edge n means `interrupt` = 0 after edge n and `VECTOR` is frozen from `act` as it was before edge n.
- **EOI:** EOI at edge m means state = `IDLE` after m. If `act != 0`, `interrupt` = 1 again after m+1.
- **Same-cycle clear:** a W1C of the only active bit in `ASSERT` without ack gives `interrupt` = 0 after edge+1. The bit is cleared at the edge, and the FSM drops to `IDLE` on the following edge.
- **Edge-mode pulses:** pulses shorter than one clock period may be missed. Sources must hold at least 2 cycles.

## Test plan
1. **Reset and register access:** reset, then write `MASK` = `8'h01` and `EDGE` = `8'h01`; read back +1 = `8'h01`, +2 = `8'h01`; read +0 = `8'h00`, +3 = `8'h00`, `interrupt` = 0.
2. **Single edge source:** with `MASK` = `8'h01`, pulse `irq_src[0]` high for 3 cycles.
   - `interrupt` rises 3 edges after the rise.
   - Ack gives `interrupt` = 0 and `VECTOR` = `8'h80`.
   - W1C +0 with `8'h01`, then EOI, keeps `interrupt` = 0.
3. **Priority and freeze:** `MASK` = `8'hFF`, level sources 5 and 2 held high.
   - Ack gives `VECTOR` = `8'h82`.
   - Raising source 0 during `SERVICE` leaves `VECTOR` = `8'h82`.
   - EOI gives `interrupt` = 1 one edge later, and the live vector reads `8'h80`.
4. **Masking:**
   - Pending bit 3 with `MASK` = 0 gives `interrupt` = 0.
   - Setting `MASK` = `8'h08` gives `interrupt` = 1 after 2 edges.
   - Clearing `MASK` before ack returns `interrupt` to 0 and the state to `IDLE`.
5. **Set vs clear collision:** a level source held high while W1C is written to its bit leaves `PEND` still 1. An edge source whose rising edge is detected in the same cycle as its W1C also stays 1.
6. **Reset mid-service:** assert `rst` in `SERVICE` with `PEND` = `8'hFF`; after one edge all registers = 0, `interrupt` = 0, and ack is ignored.
